bg_map_fetcher: RTL and testbench

- Per-scanline background tile-map fetcher in the GPU.
- On a line-start pulse it reads the 20 visible background tile indices from the BG tile map in VRAM and writes them into the 20-entry scanline RAM at addresses 0..19.
- The pixel pipeline reads tile indices from the scanline RAM port B.
- VRAM reads use a req/ack handshake so the VRAM arbiter can stall the fetcher.

---
 rtl/bg_map_fetcher_pkg.sv | 21 ++
 rtl/bg_map_addr.sv | 29 ++
 rtl/bg_map_fetcher.sv | 139 +++++++++++++
 tb/tb_bg_map_fetcher.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bg_map_fetcher_pkg.sv
// Shared constants and state type for the background tile-map fetcher.
// Map bases are VRAM byte offsets; addresses are 13 bits wide.
package bg_map_fetcher_pkg;

    localparam int          BG_TILES     = 20;
    localparam int          VRAM_AW      = 13;
    localparam logic [12:0] BG_MAP0_BASE = 13'h1800;
    localparam logic [12:0] BG_MAP1_BASE = 13'h1C00;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } fetchState_t;

    function automatic logic [9:0] mapOffset(input logic [4:0] trow, input logic [4:0] col);
        return {trow, col};
    endfunction

endpackage

// File: rtl/bg_map_addr.sv
// Combinational BG map address: base + {tile row, tile column}.
// Row and column both wrap modulo the 32x32 map.
module bg_map_addr
    import bg_map_fetcher_pkg::*;
#(
    parameter logic [12:0] MAP0_BASE = BG_MAP0_BASE,
    parameter logic [12:0] MAP1_BASE = BG_MAP1_BASE
) (
    input  logic [7:0]  ly,
    input  logic [7:0]  scy,
    input  logic [7:0]  scx,
    input  logic [4:0]  tileIdx,
    input  logic        mapSel,
    output logic [12:0] addr
);

    logic [3:0] fineSum;
    logic [4:0] trow;
    logic [4:0] col;

    always_comb begin
        // ((ly + scy) mod 256) >> 3, formed from the coarse parts plus the fine-row carry
        fineSum = {1'b0, ly[2:0]} + {1'b0, scy[2:0]};
        trow    = ly[7:3] + scy[7:3] + {4'b0000, fineSum[3]};
        col     = scx[7:3] + tileIdx;
        addr    = (mapSel ? MAP1_BASE : MAP0_BASE) + {3'b000, mapOffset(trow, col)};
    end

endmodule

// File: rtl/bg_map_fetcher.sv
// Per-scanline BG tile-map fetcher: reads TILES map bytes over a req/ack
// VRAM port and writes them to scanline RAM entries 0..TILES-1.
module bg_map_fetcher
    import bg_map_fetcher_pkg::*;
#(
    parameter int          TILES     = BG_TILES,
    parameter logic [12:0] MAP0_BASE = BG_MAP0_BASE,
    parameter logic [12:0] MAP1_BASE = BG_MAP1_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  ly,
    input  logic [7:0]  scy,
    input  logic [7:0]  scx,
    input  logic        map_sel,
    output logic        vram_rd_req,
    output logic [12:0] vram_addr,
    input  logic        vram_rd_ack,
    input  logic [7:0]  vram_rd_data,
    output logic        sl_wr_en,
    output logic [4:0]  sl_addr,
    output logic [7:0]  sl_wr_data,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] LAST_TILE = 5'(TILES - 1);

    fetchState_t state;
    logic [4:0]  tileCnt;
    logic [7:0]  lyL;
    logic [7:0]  scyL;
    logic [7:0]  scxL;
    logic        mapSelL;

    logic [7:0]  addrLy;
    logic [7:0]  addrScy;
    logic [7:0]  addrScx;
    logic [4:0]  addrIdx;
    logic        addrMap;
    logic [12:0] nextAddr;

    // Address of the next request: tile 0 from the live inputs when leaving
    // IDLE, otherwise tile tileCnt+1 from the latched line parameters.
    always_comb begin
        addrLy  = (state == S_IDLE) ? ly      : lyL;
        addrScy = (state == S_IDLE) ? scy     : scyL;
        addrScx = (state == S_IDLE) ? scx     : scxL;
        addrMap = (state == S_IDLE) ? map_sel : mapSelL;
        addrIdx = (state == S_IDLE) ? 5'd0    : tileCnt + 5'd1;
    end

    bg_map_addr #(
        .MAP0_BASE (MAP0_BASE),
        .MAP1_BASE (MAP1_BASE)
    ) uAddr (
        .ly      (addrLy),
        .scy     (addrScy),
        .scx     (addrScx),
        .tileIdx (addrIdx),
        .mapSel  (addrMap),
        .addr    (nextAddr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            tileCnt     <= 5'd0;
            lyL         <= 8'd0;
            scyL        <= 8'd0;
            scxL        <= 8'd0;
            mapSelL     <= 1'b0;
            vram_rd_req <= 1'b0;
            vram_addr   <= 13'd0;
            sl_wr_en    <= 1'b0;
            sl_addr     <= 5'd0;
            sl_wr_data  <= 8'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done     <= 1'b0;
            sl_wr_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        lyL         <= ly;
                        scyL        <= scy;
                        scxL        <= scx;
                        mapSelL     <= map_sel;
                        tileCnt     <= 5'd0;
                        vram_rd_req <= 1'b1;
                        vram_addr   <= nextAddr;
                        busy        <= 1'b1;
                        state       <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (abort) begin
                        vram_rd_req <= 1'b0;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else if (vram_rd_ack) begin
                        vram_rd_req <= 1'b0;
                        sl_wr_en    <= 1'b1;
                        sl_addr     <= tileCnt;
                        sl_wr_data  <= vram_rd_data;
                        state       <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (tileCnt == LAST_TILE) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        tileCnt     <= tileCnt + 5'd1;
                        vram_rd_req <= 1'b1;
                        vram_addr   <= nextAddr;
                        state       <= S_FETCH;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    vram_rd_req <= 1'b0;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bg_map_fetcher.sv
// Randomized bench for bg_map_fetcher: a VRAM model with random ack latency
// and an arithmetic address model checked against every request and write.
module tb_bg_map_fetcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  ly;
    logic [7:0]  scy;
    logic [7:0]  scx;
    logic        map_sel;
    logic        vram_rd_req;
    logic [12:0] vram_addr;
    logic        vram_rd_ack;
    logic [7:0]  vram_rd_data;
    logic        sl_wr_en;
    logic [4:0]  sl_addr;
    logic [7:0]  sl_wr_data;
    logic        busy;
    logic        done;

    bg_map_fetcher dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .ly           (ly),
        .scy          (scy),
        .scx          (scx),
        .map_sel      (map_sel),
        .vram_rd_req  (vram_rd_req),
        .vram_addr    (vram_addr),
        .vram_rd_ack  (vram_rd_ack),
        .vram_rd_data (vram_rd_data),
        .sl_wr_en     (sl_wr_en),
        .sl_addr      (sl_addr),
        .sl_wr_data   (sl_wr_data),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int          errCount   = 0;
    int          checkCount = 0;
    logic [7:0]  vram [0:8191];
    logic [7:0]  slModel [0:19];
    int          writeCount;
    logic [12:0] firstAddr;
    logic [12:0] lastAddr;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: map row from the wrapped scrolled line, column wraps in 32.
    function automatic logic [12:0] refAddr(input int l, input int sy, input int sx, input int sel, input int i);
        int row;
        int col;
        row = (l + sy) % 256;
        col = (sx / 8 + i) % 32;
        return 13'((sel != 0 ? 32'h1C00 : 32'h1800) + (row / 8) * 32 + col);
    endfunction

    task automatic runLine(input int l, input int sy, input int sx, input int sel,
                           input int maxDelay, input int abortTile, input int restartCyc,
                           input bit startAtDone);
        int          tile     = 0;
        int          waited   = 0;
        int          delay    = 0;
        int          cyc      = 0;
        bit          inReq    = 0;
        bit          acked    = 0;
        bit          finished = 0;
        bit          aborted  = 0;
        bit          zeroWait = 1;
        logic [12:0] reqAddr  = '0;
        logic [7:0]  ackData  = '0;
        writeCount = 0;
        firstAddr  = '0;
        lastAddr   = '0;
        @(negedge clk);
        ly = 8'(l); scy = 8'(sy); scx = 8'(sx); map_sel = sel[0]; start = 1'b1;
        @(negedge clk);
        while (!finished && cyc < 400) begin
            cyc++;
            start = 1'b0; abort = 1'b0; vram_rd_ack = 1'b0;
            ly = 8'($urandom); scy = 8'($urandom); scx = 8'($urandom); map_sel = 1'($urandom);
            if (aborted) begin
                checkVal("abortBusy", busy, 0);
                checkVal("abortReq", vram_rd_req, 0);
                for (int k = 0; k < 4; k++) begin
                    checkVal("abortQuiet", {30'd0, sl_wr_en, done}, 0);
                    @(negedge clk);
                end
                finished = 1;
            end else begin
                if (vram_rd_req) begin
                    if (!inReq) begin
                        inReq   = 1;
                        waited  = 0;
                        delay   = $urandom_range(maxDelay, 0);
                        if (delay != 0) zeroWait = 0;
                        reqAddr = vram_addr;
                        checkVal($sformatf("fetchAddr[%0d]", tile), vram_addr, refAddr(l, sy, sx, sel, tile));
                        if (tile == 0) firstAddr = vram_addr;
                        lastAddr = vram_addr;
                    end else begin
                        checkVal("addrStable", vram_addr, reqAddr);
                    end
                    if (tile == abortTile) begin
                        abort   = 1'b1;
                        aborted = 1;
                    end else if (waited == delay) begin
                        vram_rd_ack  = 1'b1;
                        vram_rd_data = vram[vram_addr];
                        ackData      = vram_rd_data;
                        acked        = 1;
                        inReq        = 0;
                    end else begin
                        waited++;
                        vram_rd_data = 8'($urandom);
                    end
                end else begin
                    if (inReq) checkVal("reqHeld", 0, 1);
                    vram_rd_ack  = ($urandom_range(3, 0) == 0);
                    vram_rd_data = 8'($urandom);
                end
                if (sl_wr_en) begin
                    checkVal("wrAfterAck", {31'd0, acked}, 1);
                    acked = 0;
                    checkVal("slAddr", sl_addr, writeCount);
                    checkVal("slData", sl_wr_data, ackData);
                    if (sl_addr < 20) slModel[sl_addr] = sl_wr_data;
                    writeCount++;
                    tile++;
                end
                if (done) begin
                    checkVal("writeCount", writeCount, 20);
                    if (zeroWait) checkVal("doneCycle", cyc, 41);
                    finished = 1;
                    if (startAtDone) start = 1'b1;
                end
                if (cyc == restartCyc) start = 1'b1;
                @(negedge clk);
            end
        end
        start = 1'b0; abort = 1'b0; vram_rd_ack = 1'b0;
        if (!finished) checkVal("lineTimeout", 0, 1);
        else if (!aborted) begin
            checkVal("busyAfterDone", busy, 0);
            checkVal("donePulse", done, 0);
            @(negedge clk);
            checkVal("idleAfterDone", {30'd0, busy, vram_rd_req}, 0);
        end
        $display("line ly=%02h scy=%02h scx=%02h sel=%0d writes=%0d cycles=%0d aborted=%0d",
                 l, sy, sx, sel, writeCount, cyc, aborted);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; ly = '0; scy = '0; scx = '0;
        map_sel = 1'b0; vram_rd_ack = 1'b0; vram_rd_data = '0;
        for (int a = 0; a < 8192; a++) vram[a] = 8'(a);
        #3;
        checkVal("resetOutputs", {vram_rd_req, vram_addr, sl_wr_en, sl_addr, sl_wr_data, busy, done}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkVal("idleBusy", busy, 0);

        // Plain line, read data = low address byte
        runLine(8'h00, 8'h00, 8'h00, 0, 0, -1, -1, 0);
        checkVal("t1First", firstAddr, 13'h1800);
        checkVal("t1Last", lastAddr, 13'h1813);
        checkVal("t1Entry0", slModel[0], 8'h00);
        checkVal("t1Entry19", slModel[19], 8'h13);

        // Column wrap on map 1, start coinciding with DONE
        runLine(8'h00, 8'h00, 8'hF8, 1, 0, -1, -1, 1);
        checkVal("t2First", firstAddr, 13'h1C1F);
        checkVal("t2Last", lastAddr, 13'h1C12);

        // Row wrap, second start mid-line
        runLine(8'h90, 8'h80, 8'h10, 0, 0, -1, 10, 0);
        checkVal("t3First", firstAddr, 13'h1842);
        checkVal("t3Last", lastAddr, 13'h1855);

        for (int a = 0; a < 8192; a++) vram[a] = 8'($urandom);
        for (int n = 0; n < 4; n++)
            runLine($urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(255, 0),
                    $urandom_range(1, 0), 3, -1, -1, 0);

        // Abort during fetch of tile 7, then refetch from tile 0
        begin
            int l  = $urandom_range(255, 0);
            int sy = $urandom_range(255, 0);
            int sx = $urandom_range(255, 0);
            for (int k = 0; k < 20; k++) slModel[k] = 8'hxx;
            runLine(l, sy, sx, 1, 2, 7, -1, 0);
            checkVal("abortWrites", writeCount, 7);
            for (int k = 0; k < 7; k++)
                checkVal($sformatf("keptEntry[%0d]", k), slModel[k], vram[refAddr(l, sy, sx, 1, k)]);
            runLine(l, sy, sx, 1, 2, -1, -1, 0);
            checkVal("refetchFirst", firstAddr, refAddr(l, sy, sx, 1, 0));
        end

        // Asynchronous reset mid-line
        @(negedge clk);
        ly = 8'h12; scy = 8'h34; scx = 8'h56; map_sel = 1'b1; start = 1'b1; vram_rd_ack = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        checkVal("preRstBusy", busy, 1);
        #2 rst = 1'b1;
        #1;
        checkVal("asyncRstOutputs", {vram_rd_req, vram_addr, sl_wr_en, sl_addr, sl_wr_data, busy, done}, 0);
        @(negedge clk);
        rst = 1'b0; vram_rd_ack = 1'b0;
        @(negedge clk);
        checkVal("postRstIdle", {30'd0, busy, vram_rd_req}, 0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
